// File: rtl/lane_merge_packer.sv
// lane_merge_packer: handshaked little-endian lane packer with zero/sign extension of unfilled lanes
module lane_merge_packer #(
  parameter int LANE_W = 8,
  parameter int LANES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [LANE_W-1:0] in_data,
  input  logic in_last,
  input  logic sign_ext,
  output logic out_valid,
  input  logic out_ready,
  output logic [LANE_W*LANES-1:0] out_data,
  output logic [$clog2(LANES+1)-1:0] out_count
);
  localparam int OUT_W = LANE_W * LANES;
  localparam int CW = $clog2(LANES + 1);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  typedef enum logic {EMPTY, FILL} state_t;
  state_t state, state_next;
  logic [IW-1:0] cnt;
  logic [OUT_W-1:0] acc, word;
  logic mode, mode_cur, accept, complete;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign complete = accept && (in_last || cnt == IW'(LANES - 1));
  assign mode_cur = state == EMPTY ? sign_ext : mode;
  // Lanes below cnt come from the accumulator, lane cnt is the incoming lane, the rest are extension.
  always_comb begin
    state_next = state;
    word = '0;
    if (accept) state_next = complete ? EMPTY : FILL;
    for (int i = 0; i < LANES; i++)
      word[i*LANE_W +: LANE_W] = IW'(i) < cnt ? acc[i*LANE_W +: LANE_W] :
                                 IW'(i) == cnt ? in_data :
                                 {LANE_W{mode_cur && in_data[LANE_W-1]}};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      cnt <= '0;
      acc <= '0;
      mode <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_count <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt <= complete ? '0 : cnt + IW'(1);
        acc <= complete ? '0 : word;
        if (state == EMPTY) mode <= sign_ext;
      end
      if (complete) begin
        out_valid <= 1'b1;
        out_data <= word;
        out_count <= CW'(cnt) + CW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lane_merge_packer.sv
// tb_lane_merge_packer: table vectors, corner sequences and a randomized run against a lane-list model
module tb_lane_merge_packer;
  localparam int LANES = 4;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, in_last, sign_ext, out_valid, out_ready;
  logic [7:0] in_data;
  logic [31:0] out_data;
  logic [2:0] out_count;
  int checks = 0, errors = 0;

  lane_merge_packer #(.LANE_W(8), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .sign_ext(sign_ext),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    logic [7:0] d;
    logic last, sext, ev;
    logic [31:0] ed;
    logic [2:0] ec;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic last, logic sext, logic ev, logic [31:0] ed, logic [2:0] ec);
    vec_t r;
    r.v = v; r.d = d; r.last = last; r.sext = sext; r.ev = ev; r.ed = ed; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic last, input logic sext, input logic ordy);
    in_valid = v; in_data = d; in_last = last; sign_ext = sext; out_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(0, 8'h00, 0, 0, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  // reference model state: list of lanes accepted into the current word plus the pending output
  int k;
  logic [7:0] lanes [LANES];
  logic mmode, mv, ir, comp, rv, rl, rs, ro;
  logic [7:0] rd;
  logic [31:0] md;
  logic [2:0] mc;

  function automatic logic [31:0] pack(int n, logic m);
    longint w = 0;
    for (int i = 0; i < n; i++) w |= longint'(lanes[i]) << (8 * i);
    if (m && lanes[n-1][7]) w |= ~((longint'(1) << (8 * n)) - 1);
    return w[31:0];
  endfunction

  initial begin
    drive(0, 8'h00, 0, 0, 1);
    reset = 1'b1;
    tick;
    tick;
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_count", out_count, 0);
    reset = 1'b0;
    #1 chk("reset_in_ready", in_ready, 1);

    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h22, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h33, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h44, 0, 0, 1, 32'h44332211, 4));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h34, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h92, 1, 0, 1, 32'h00009234, 2));
    tbl.push_back(mk(1, 8'h34, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h92, 1, 0, 1, 32'hFFFF9234, 2));
    tbl.push_back(mk(1, 8'h34, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h12, 1, 1, 1, 32'h00001234, 2));
    tbl.push_back(mk(1, 8'h80, 1, 1, 1, 32'hFFFFFF80, 1));
    tbl.push_back(mk(1, 8'h7F, 1, 1, 1, 32'h0000007F, 1));
    tbl.push_back(mk(1, 8'h85, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h90, 1, 1, 1, 32'h00009085, 2));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0));
    foreach (tbl[n]) begin
      drive(tbl[n].v, tbl[n].d, tbl[n].last, tbl[n].sext, 1);
      #1 chk($sformatf("tbl%0d_in_ready", n), in_ready, 1);
      tick;
      chk($sformatf("tbl%0d_valid", n), out_valid, tbl[n].ev);
      if (tbl[n].ev) begin
        chk($sformatf("tbl%0d_data", n), out_data, tbl[n].ed);
        chk($sformatf("tbl%0d_count", n), out_count, tbl[n].ec);
      end
    end

    for (int i = 0; i < 4; i++) begin
      drive(1, 8'hA1 + 8'(i), 0, 0, 0);
      tick;
    end
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 32'hA4A3A2A1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'hB1, 0, 0, 0);
      #1 chk("bp_in_ready_low", in_ready, 0);
      tick;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 32'hA4A3A2A1);
      chk("bp_hold_count", out_count, 4);
    end
    drive(1, 8'hB1, 0, 0, 1);
    #1 chk("bp_release_in_ready", in_ready, 1);
    tick;
    chk("bp_release_valid", out_valid, 0);
    drive(1, 8'hB2, 0, 0, 1);
    tick;
    drive(1, 8'hB3, 0, 0, 1);
    tick;
    drive(1, 8'hB4, 1, 0, 1);
    tick;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_data", out_data, 32'hB4B3B2B1);
    chk("bp_next_count", out_count, 4);

    for (int i = 1; i <= 8; i++) begin
      drive(1, 8'(i), 0, 0, 1);
      #1 chk("stream_in_ready", in_ready, 1);
      tick;
      chk($sformatf("stream%0d_valid", i), out_valid, (i == 4 || i == 8) ? 1 : 0);
      if (i == 4) chk("stream_word0", out_data, 32'h04030201);
      if (i == 8) chk("stream_word1", out_data, 32'h08070605);
    end

    drive(1, 8'hEE, 0, 1, 1);
    tick;
    drive(1, 8'hDD, 0, 0, 1);
    tick;
    do_reset;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_count", out_count, 0);
    chk("rst_mid_data", out_data, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'(i), 0, i == 1, 1);
      tick;
    end
    chk("rst_after_valid", out_valid, 1);
    chk("rst_after_data", out_data, 32'h04030201);
    chk("rst_after_count", out_count, 4);
    drive(1, 8'hEE, 0, 1, 1);
    tick;
    do_reset;
    drive(1, 8'h01, 0, 0, 1);
    tick;
    drive(1, 8'h02, 0, 1, 1);
    tick;
    drive(1, 8'h83, 1, 1, 1);
    tick;
    chk("rst_mode_valid", out_valid, 1);
    chk("rst_mode_data", out_data, 32'h00830201);
    chk("rst_mode_count", out_count, 3);

    do_reset;
    k = 0; mmode = 0; mv = 0; md = 0; mc = 0;
    repeat (3000) begin
      rv = $urandom_range(0, 3) != 0;
      rd = 8'($urandom);
      rl = $urandom_range(0, 3) == 0;
      rs = 1'($urandom);
      ro = $urandom_range(0, 3) != 0;
      drive(rv, rd, rl, rs, ro);
      #1;
      ir = !mv || ro;
      chk("rnd_in_ready", in_ready, ir);
      comp = 0;
      if (rv && ir) begin
        if (k == 0) mmode = rs;
        lanes[k] = rd;
        k++;
        if (rl || k == LANES) begin
          comp = 1;
          md = pack(k, mmode);
          mc = 3'(k);
          k = 0;
        end
      end
      if (comp) mv = 1;
      else if (ro) mv = 0;
      tick;
      chk("rnd_valid", out_valid, mv);
      if (mv) begin
        chk("rnd_data", out_data, md);
        chk("rnd_count", out_count, mc);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
